// File: rtl/hash_state_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hash_state_deserializer_pkg
//  Purpose  : Shared SHA-256 working-state types and the word index type.
//  Revision : 1.0 - initial release
// ============================================================================
package hash_state_deserializer_pkg;

    localparam int NWORDS = 8;

    typedef logic [2:0] StateIdx;

    // Field a sits in the most significant bits, matching {a..h} concatenation.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

endpackage
`default_nettype wire

// File: rtl/hash_state_deserializer_field_reg.sv
`default_nettype none
// ============================================================================
//  Module   : hash_state_deserializer_field_reg
//  Purpose  : Enabled field register with asynchronous active-low clear.
//  Revision : 1.0 - initial release
// ============================================================================
module hash_state_deserializer_field_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/hash_state_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : hash_state_deserializer
//  Purpose  : Collects eight serial 32-bit words a..h into one HashState.
//  Revision : 1.0 - initial release
// ============================================================================
module hash_state_deserializer
    import hash_state_deserializer_pkg::*;
#(
    parameter int NWORDS = 8,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output HashState         out_state,
    output logic             err
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } collect_state_t;

    localparam StateIdx c_last_idx = StateIdx'(NWORDS - 1);

    collect_state_t   r_state;
    collect_state_t   w_state_next;
    StateIdx          r_cnt;
    StateIdx          w_cnt_next;
    HashState         r_out_state;
    HashState         w_frame;
    logic             r_out_valid;
    logic             r_err;
    logic             w_err_next;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_load_out;
    logic             w_load_direct;
    logic [NWORDS-1:0] w_wr_en;
    logic [WIDTH-1:0] w_words [NWORDS];

    assign w_accept    = in_valid && w_in_ready;
    assign w_slot_free = !r_out_valid || out_ready;

    // A first-marked word always restarts at slot a; otherwise cnt steers it.
    for (genvar k = 0; k < NWORDS; k++) begin : g_field
        assign w_wr_en[k] = w_accept &&
                            (in_first ? (k == 0)
                                      : ((r_cnt != '0) && (r_cnt == StateIdx'(k))));

        hash_state_deserializer_field_reg #(
            .WIDTH (WIDTH)
        ) u_field (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_wr_en[k]),
            .d     (in_data),
            .q     (w_words[k])
        );
    end

    // On the fast path h bypasses its field register so the frame lands one edge after the h beat.
    always_comb begin
        w_frame = '{a: w_words[0], b: w_words[1], c: w_words[2], d: w_words[3],
                    e: w_words[4], f: w_words[5], g: w_words[6],
                    h: (w_load_direct ? in_data : w_words[7])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_in_ready    = 1'b0;
        w_load_out    = 1'b0;
        w_load_direct = 1'b0;
        w_err_next    = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (in_first) begin
                        w_cnt_next = StateIdx'(1);
                        w_err_next = (r_cnt != '0);
                    end else if (r_cnt == '0) begin
                        w_err_next = 1'b1;
                    end else if (r_cnt == c_last_idx) begin
                        if (w_slot_free) begin
                            w_load_out    = 1'b1;
                            w_load_direct = 1'b1;
                            w_cnt_next    = '0;
                        end else begin
                            w_state_next = S_FULL;
                        end
                    end else begin
                        w_cnt_next = r_cnt + StateIdx'(1);
                    end
                end
            end
            S_FULL: begin
                if (w_slot_free) begin
                    w_load_out   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_COLLECT;
                end
            end
            default: begin
                w_state_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_err <= w_err_next;
            if (w_load_out) begin
                r_out_state <= w_frame;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hash_state_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hash_state_deserializer
//  Purpose  : Scoreboard bench for the HashState serial-to-parallel collector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hash_state_deserializer;
    import hash_state_deserializer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_first;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    HashState    out_state;
    logic        err;

    int          n_tests;
    int          n_fail;
    int          err_cnt;
    int          cyc;
    HashState    sb_q[$];
    int          take_cyc[$];

    hash_state_deserializer #(
        .NWORDS (8),
        .WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every frame taken by the consumer must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_cnt++;
            if (out_valid && out_ready) begin
                HashState exp_s;
                take_cyc.push_back(cyc);
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no frame", out_state);
                end else begin
                    exp_s = sb_q.pop_front();
                    if (out_state !== exp_s) begin
                        n_fail++;
                        $display("FAIL frame_data: got %h, expected %h", out_state, exp_s);
                    end
                end
            end
        end
    end

    function automatic HashState mk_seq(input logic [31:0] base);
        HashState s;
        for (int i = 0; i < 8; i++) s[255-32*i -: 32] = base + 32'(i);
        return s;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic f);
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_frame(input HashState s);
        for (int i = 0; i < 8; i++) send_word(s[255-32*i -: 32], (i == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
        n_tests++; if (out_state !== '0) begin n_fail++; $display("FAIL reset_out_state: got %h, expected 0", out_state); end
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        HashState s;
        s = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        out_ready = 1'b1;
        err_cnt   = 0;
        sb_q.push_back(s);
        send_frame(s);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid got %b, expected 1", out_valid); end
        n_tests++; if (out_state.a !== 32'h6a09e667) begin n_fail++; $display("FAIL single_a: got %h, expected 6a09e667", out_state.a); end
        n_tests++; if (out_state.h !== 32'h5be0cd19) begin n_fail++; $display("FAIL single_h: got %h, expected 5be0cd19", out_state.h); end
        idle(1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: out_valid got %b, expected 0", out_valid); end
        idle(2);
        n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL single_err: err pulses %0d, expected 0", err_cnt); end
    endtask

    task automatic test_back_to_back;
        int ready_low;
        ready_low = 0;
        out_ready = 1'b1;
        take_cyc.delete();
        sb_q.push_back(mk_seq(32'd1));
        sb_q.push_back(mk_seq(32'd9));
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            in_first = ((i % 8) == 0);
            #1;
            if (in_ready !== 1'b1) ready_low++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        idle(2);
        n_tests++; if (ready_low !== 0) begin n_fail++; $display("FAIL b2b_in_ready: low on %0d beats, expected 0", ready_low); end
        n_tests++;
        if (take_cyc.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d frames, expected 2", take_cyc.size());
        end else if (take_cyc[1] - take_cyc[0] != 8) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles, expected 8", take_cyc[1] - take_cyc[0]);
        end
    endtask

    task automatic test_backpressure;
        HashState f1;
        HashState f2;
        f1 = mk_seq(32'h1000_0000);
        f2 = mk_seq(32'h2000_0000);
        out_ready = 1'b0;
        sb_q.push_back(f1);
        sb_q.push_back(f2);
        send_frame(f1);
        send_frame(f2);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b, expected 0", in_ready); end
        n_tests++; if (out_state !== f1) begin n_fail++; $display("FAIL bp_hold: got %h, expected %h", out_state, f1); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", out_valid); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++; if (out_state !== f2) begin n_fail++; $display("FAIL bp_release: got %h, expected %h", out_state, f2); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b, expected 1", in_ready); end
        idle(2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: out_valid got %b, expected 0", out_valid); end
    endtask

    task automatic test_resync;
        HashState s;
        s   = mk_seq(32'h3000_0000);
        s.a = 32'hAAAA0000;
        out_ready = 1'b1;
        err_cnt   = 0;
        sb_q.push_back(s);
        send_word(32'h0BAD_0001, 1'b1);
        send_word(32'h0BAD_0002, 1'b0);
        send_word(32'h0BAD_0003, 1'b0);
        send_frame(s);
        idle(2);
        n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL resync_err: err pulses %0d, expected 1", err_cnt); end
    endtask

    task automatic test_orphan;
        HashState s;
        s = mk_seq(32'h4000_0000);
        out_ready = 1'b1;
        err_cnt   = 0;
        sb_q.push_back(s);
        send_word(32'hDEADBEEF, 1'b0);
        send_frame(s);
        idle(2);
        n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL orphan_err: err pulses %0d, expected 1", err_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        HashState s;
        s = mk_seq(32'h5000_0000);
        out_ready = 1'b0;
        send_frame(mk_seq(32'h7700_0000));
        for (int i = 0; i < 5; i++) send_word(32'h6600_0000 + 32'(i), (i == 0));
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b, expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready); end
        @(negedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        err_cnt = 0;
        sb_q.push_back(s);
        send_frame(s);
        idle(3);
        n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_err: err pulses %0d, expected 0", err_cnt); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        err_cnt   = 0;
        cyc       = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_orphan();
        test_reset_mid_frame();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hash_state_deserializer.md
Name: hash_state_deserializer

Overview:
- Serial-to-parallel collector for SHA-256 working state: accepts one 32-bit word per handshake, in order a,b,c,d,e,f,g,h, and presents the assembled HashState as a single parallel word with valid/ready.
- Counterpart of the core's word-serial state unloader. Sits between a 32-bit word stream (unload path, host/bus loader) and any consumer of a full HashState (core reload, result compare).

Parameters:
- NWORDS, 8, words per frame; fixed by HashState and must not be overridden.
- WIDTH, 32, bits per word; must equal the HashState field width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_first valid this cycle.
- in_first  in  1  marks word a, the first word of a frame.
- in_data  in  WIDTH  serial word.
- in_ready  out  1  collector can accept a word.
- out_valid  out  1  out_state holds a complete frame.
- out_ready  in  1  consumer takes out_state this cycle.
- out_state  out  HashState  assembled state {a..h}.
- err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, sync deassert handled upstream): cnt=0, state COLLECT, assembly regs and out_state=0, out_valid=0, in_ready=1, err=0.
- Accept = in_valid && in_ready. out_take = out_valid && out_ready. slot_free = !out_valid || out_ready.
- COLLECT: in_ready=1. On accept, word k=cnt goes to field k (0=a .. 7=h), and cnt increments.
- Framing rule 1: accept with in_first=1 and cnt!=0. Drop the partial frame, store the word as a, set cnt=1, pulse err.
- Framing rule 2: accept with in_first=0 and cnt==0. Discard the word, keep cnt=0, pulse err.
- Accept of the 8th word (cnt==7, in_first=0):
  - If slot_free: load out_state with {a..g, in_data} at that edge, so out_valid=1 the next cycle (latency 1 from the h beat). Set cnt=0 and stay in COLLECT. No bubble, so back-to-back frames run at 1 word/cycle.
  - Else: latch h, go to FULL.
- FULL: in_ready=0. When slot_free, transfer the assembled frame to out_state, set out_valid=1 (1 cycle after out_ready is seen), cnt=0, then COLLECT.
- Output register: out_valid clears on out_take unless a new frame loads the same edge, in which case it stays 1 with the new data. out_state holds stable while out_valid && !out_ready.
- The assembly registers do not alter out_state until a transfer.
- Reset mid-frame or mid-FULL: partial and pending frames are lost. No err.
- in_data and in_first are ignored when !in_valid or !in_ready.
- err is registered, asserted the cycle after the offending accept, and never blocks flow.

Decomposition:
- Shared sha package (existing): the HashState typedef (fields a..h, 32 bits each) and the constant NWORDS=8. Add a StateIdx typedef (3-bit word index). Add a collector FSM enum {COLLECT, FULL} only if another block reuses it; otherwise it stays local.
- Sub-module: the existing FF wrapper for each field register. No other sub-module; word steering is a decoder on cnt inside this block.

Test Plan:
- Single frame: feed words 0x6a09e667,0xbb67ae85,0x3c6ef372,0xa54ff53a,0x510e527f,0x9b05688c,0x1f83d9ab,0x5be0cd19 (first on word 0), with out_ready=1. Required: out_valid for exactly 1 cycle, 1 cycle after the h beat, with out_state.a=0x6a09e667 and out_state.h=0x5be0cd19; err never asserts.
- Back-to-back: two frames with word values 1..8 then 9..16, in_valid held high, out_ready=1. Required: in_ready stays 1 throughout; outputs {1..8} then {9..16}, 8 cycles apart.
- Backpressure: out_ready=0 while the first frame is output and the second frame completes. Required: after the 8th word of frame 2, in_ready=0 (FULL) and out_state holds frame 1. Raising out_ready for 1 cycle then shows frame 2 the next cycle, and in_ready returns to 1.
- Resync: send 3 words, then in_first=1 with 0xAAAA0000 followed by 7 more words. Required: err pulses once, and the output frame has a=0xAAAA0000 with no stale words.
- Orphan word: with cnt=0, send in_first=0 data 0xDEADBEEF. Required: err pulses, the word is discarded, and the next proper frame is output intact.
- Reset mid-frame: assert rst_n=0 asynchronously after 5 words, with no clock edge. Required: out_valid=0 and in_ready=1 immediately. After release, a full frame is output correctly with no err.
